// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Two-port round-robin arbiter in front of a single memory
//            interface, with per-port pending slots and a WAIT-state timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int TIMEOUT = 4095
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req0_type,
  input  logic [15:0] req0_addr,
  input  logic [15:0] req0_wdata,
  input  logic        req1,
  input  logic        req1_type,
  input  logic [15:0] req1_addr,
  input  logic [15:0] req1_wdata,
  output logic        busy0,
  output logic        busy1,
  output logic        rdy0,
  output logic        rdy1,
  output logic        wdone0,
  output logic        wdone1,
  output logic        err0,
  output logic        err1,
  output logic [15:0] rdata,
  output logic        owner,
  output logic        timeout_flag,
  input  logic        clear_err,
  output logic        mem_request,
  output logic        mem_type,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ready,
  input  logic        mem_write_complete,
  input  logic [15:0] mem_rdata
);

  localparam int                 c_CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]         r_pend, w_pend_nxt;
  logic [1:0]         r_ptype, w_ptype_nxt;
  logic [1:0][15:0]   r_paddr, w_paddr_nxt;
  logic [1:0][15:0]   r_pwdata, w_pwdata_nxt;
  logic [1:0]         r_busy, w_busy_nxt;
  logic [1:0]         r_rdy, w_rdy_nxt;
  logic [1:0]         r_wdone, w_wdone_nxt;
  logic [1:0]         r_err, w_err_nxt;
  logic [15:0]        r_rdata, w_rdata_nxt;
  logic               r_owner, w_owner_nxt;
  logic               r_tflag, w_tflag_nxt;
  logic               r_mem_req, w_mem_req_nxt;
  logic               r_mem_type, w_mem_type_nxt;
  logic [15:0]        r_mem_addr, w_mem_addr_nxt;
  logic [15:0]        r_mem_wdata, w_mem_wdata_nxt;

  logic [1:0]         w_req;
  logic [1:0]         w_req_type;
  logic [1:0][15:0]   w_req_addr;
  logic [1:0][15:0]   w_req_wdata;
  logic               w_win;
  logic               w_match;

  assign w_req       = {req1, req0};
  assign w_req_type  = {req1_type, req0_type};
  assign w_req_addr  = {req1_addr, req0_addr};
  assign w_req_wdata = {req1_wdata, req0_wdata};

  // On a tie the port that was not granted last wins; otherwise the only pending port.
  assign w_win   = (r_pend == 2'b11) ? ~r_owner : r_pend[1];
  assign w_match = r_mem_type ? mem_write_complete : mem_ready;

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_pend_nxt      = r_pend;
    w_ptype_nxt     = r_ptype;
    w_paddr_nxt     = r_paddr;
    w_pwdata_nxt    = r_pwdata;
    w_busy_nxt      = r_busy;
    w_rdy_nxt       = 2'b00;
    w_wdone_nxt     = 2'b00;
    w_err_nxt       = 2'b00;
    w_rdata_nxt     = r_rdata;
    w_owner_nxt     = r_owner;
    w_tflag_nxt     = r_tflag;
    w_mem_req_nxt   = 1'b0;
    w_mem_type_nxt  = r_mem_type;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;

    // A request is also refused in the cycle its port's completion pulse is high.
    for (int p = 0; p < 2; p++) begin
      if (w_req[p] && !r_busy[p] && !r_rdy[p] && !r_wdone[p] && !r_err[p]) begin
        w_pend_nxt[p]   = 1'b1;
        w_busy_nxt[p]   = 1'b1;
        w_ptype_nxt[p]  = w_req_type[p];
        w_paddr_nxt[p]  = w_req_addr[p];
        w_pwdata_nxt[p] = w_req_wdata[p];
      end
    end

    if (clear_err) begin
      w_tflag_nxt = 1'b0;
    end

    case (r_state)
      ST_IDLE: begin
        if (r_pend != 2'b00) begin
          w_mem_req_nxt     = 1'b1;
          w_mem_type_nxt    = r_ptype[w_win];
          w_mem_addr_nxt    = r_paddr[w_win];
          w_mem_wdata_nxt   = r_pwdata[w_win];
          w_owner_nxt       = w_win;
          w_pend_nxt[w_win] = 1'b0;
          w_cnt_nxt         = '0;
          w_state_nxt       = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_match) begin
          if (r_mem_type) begin
            w_wdone_nxt[r_owner] = 1'b1;
          end else begin
            w_rdy_nxt[r_owner] = 1'b1;
            w_rdata_nxt        = mem_rdata;
          end
          w_busy_nxt[r_owner] = 1'b0;
          w_state_nxt         = ST_IDLE;
        end else if (r_cnt == c_CNT_LAST) begin
          w_err_nxt[r_owner]  = 1'b1;
          w_busy_nxt[r_owner] = 1'b0;
          w_tflag_nxt         = 1'b1;
          w_state_nxt         = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_pend      <= '0;
      r_ptype     <= '0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_busy      <= '0;
      r_rdy       <= '0;
      r_wdone     <= '0;
      r_err       <= '0;
      r_rdata     <= 16'h0000;
      r_owner     <= 1'b1;
      r_tflag     <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_type  <= 1'b0;
      r_mem_addr  <= 16'h0000;
      r_mem_wdata <= 16'h0000;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_pend      <= w_pend_nxt;
      r_ptype     <= w_ptype_nxt;
      r_paddr     <= w_paddr_nxt;
      r_pwdata    <= w_pwdata_nxt;
      r_busy      <= w_busy_nxt;
      r_rdy       <= w_rdy_nxt;
      r_wdone     <= w_wdone_nxt;
      r_err       <= w_err_nxt;
      r_rdata     <= w_rdata_nxt;
      r_owner     <= w_owner_nxt;
      r_tflag     <= w_tflag_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_type  <= w_mem_type_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
    end
  end

  assign busy0        = r_busy[0];
  assign busy1        = r_busy[1];
  assign rdy0         = r_rdy[0];
  assign rdy1         = r_rdy[1];
  assign wdone0       = r_wdone[0];
  assign wdone1       = r_wdone[1];
  assign err0         = r_err[0];
  assign err1         = r_err[1];
  assign rdata        = r_rdata;
  assign owner        = r_owner;
  assign timeout_flag = r_tflag;
  assign mem_request  = r_mem_req;
  assign mem_type     = r_mem_type;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed bench for mem_arbiter with a grant/response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int TIMEOUT = 8;
  localparam logic [1:0] K_RDY = 2'd0, K_WDONE = 2'd1, K_ERR = 2'd2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req0_type = 1'b0, req1 = 1'b0, req1_type = 1'b0;
  logic [15:0] req0_addr = '0, req0_wdata = '0, req1_addr = '0, req1_wdata = '0;
  logic        clear_err = 1'b0, mem_ready = 1'b0, mem_write_complete = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        busy0, busy1, rdy0, rdy1, wdone0, wdone1, err0, err1;
  logic        owner, timeout_flag, mem_request, mem_type;
  logic [15:0] rdata, mem_addr, mem_wdata;

  typedef struct packed {
    logic        port;
    logic        typ;
    logic [15:0] addr;
    logic [15:0] wdata;
  } grant_t;

  typedef struct packed {
    logic        port;
    logic [1:0]  kind;
    logic [15:0] data;
  } resp_t;

  grant_t gq[$];
  resp_t  rq[$];
  int     tests = 0;
  int     fails = 0;

  mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req0_type(req0_type), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1(req1), .req1_type(req1_type), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .busy0(busy0), .busy1(busy1), .rdy0(rdy0), .rdy1(rdy1),
    .wdone0(wdone0), .wdone1(wdone1), .err0(err0), .err1(err1),
    .rdata(rdata), .owner(owner), .timeout_flag(timeout_flag), .clear_err(clear_err),
    .mem_request(mem_request), .mem_type(mem_type), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_write_complete(mem_write_complete), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_grant(input logic p, input logic t, input logic [15:0] a, input logic [15:0] d);
    grant_t g;
    g.port = p; g.typ = t; g.addr = a; g.wdata = d;
    gq.push_back(g);
  endtask

  task automatic push_resp(input logic p, input logic [1:0] k, input logic [15:0] d);
    resp_t r;
    r.port = p; r.kind = k; r.data = d;
    rq.push_back(r);
  endtask

  task automatic req(input logic p, input logic t, input logic [15:0] a, input logic [15:0] d);
    if (p) begin
      req1 = 1'b1; req1_type = t; req1_addr = a; req1_wdata = d;
    end else begin
      req0 = 1'b1; req0_type = t; req0_addr = a; req0_wdata = d;
    end
    step();
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic do_resp(input logic wr, input logic [15:0] d);
    if (wr) mem_write_complete = 1'b1;
    else begin
      mem_ready = 1'b1;
      mem_rdata = d;
    end
    step();
    mem_ready = 1'b0;
    mem_write_complete = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ctl"}, {busy0, busy1, rdy0, rdy1, wdone0, wdone1, err0, err1,
                       mem_request, mem_type, timeout_flag, owner}, 12'h001);
    chk({tag, "_rdata"}, rdata, 16'h0000);
    chk({tag, "_mem_addr"}, mem_addr, 16'h0000);
    chk({tag, "_mem_wdata"}, mem_wdata, 16'h0000);
  endtask

  // Scoreboard monitor: every grant and every response pulse must match the queue head.
  always @(posedge clk) begin
    grant_t     g;
    resp_t      r;
    logic [5:0] pulses;
    #2;
    if (mem_request === 1'b1) begin
      if (gq.size() == 0) chk("unexpected_mem_request", mem_request, 1'b0);
      else begin
        g = gq.pop_front();
        chk("grant_port", owner, g.port);
        chk("grant_type", mem_type, g.typ);
        chk("grant_addr", mem_addr, g.addr);
        if (g.typ) chk("grant_wdata", mem_wdata, g.wdata);
      end
    end
    pulses = {err1, err0, wdone1, wdone0, rdy1, rdy0};
    if (pulses !== 6'd0) begin
      if (rq.size() == 0) chk("unexpected_response", pulses, 6'd0);
      else begin
        r = rq.pop_front();
        chk("resp_pulse", pulses, 6'b1 << (2 * r.kind + r.port));
        if (r.kind == K_RDY) chk("resp_rdata", rdata, r.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    chk_reset("reset");
    reset = 1'b0;
    step();

    // Simultaneous requests: port 0 first, then port 1, then alternation resumes at port 0.
    push_grant(1'b0, 1'b0, 16'h0100, 16'h0);
    push_grant(1'b1, 1'b0, 16'h0200, 16'h0);
    req0 = 1'b1; req0_type = 1'b0; req0_addr = 16'h0100;
    req1 = 1'b1; req1_type = 1'b0; req1_addr = 16'h0200;
    step();
    req0 = 1'b0; req1 = 1'b0;
    chk("rr_busy_both", {busy0, busy1}, 2'b11);
    step();
    chk("rr_first_req", mem_request, 1'b1);
    chk("rr_first_owner", owner, 1'b0);
    step();
    push_resp(1'b0, K_RDY, 16'h1111);
    do_resp(1'b0, 16'h1111);
    chk("rr_rdy0", rdy0, 1'b1);
    step();
    chk("rr_second_req_at_k2", mem_request, 1'b1);
    chk("rr_second_owner", owner, 1'b1);
    step();
    push_resp(1'b1, K_RDY, 16'h2222);
    do_resp(1'b0, 16'h2222);
    step();
    push_grant(1'b0, 1'b0, 16'h0300, 16'h0);
    push_grant(1'b1, 1'b0, 16'h0400, 16'h0);
    req0 = 1'b1; req0_addr = 16'h0300;
    req1 = 1'b1; req1_addr = 16'h0400;
    step();
    req0 = 1'b0; req1 = 1'b0;
    step();
    chk("rr_third_owner", owner, 1'b0);
    step();
    push_resp(1'b0, K_RDY, 16'h3333);
    do_resp(1'b0, 16'h3333);
    step();
    chk("rr_fourth_owner", owner, 1'b1);
    step();
    push_resp(1'b1, K_RDY, 16'h4444);
    do_resp(1'b0, 16'h4444);
    step();

    // Basic read with T+2 latency; duplicate requests while busy and during rdy0 are dropped.
    push_grant(1'b0, 1'b0, 16'h0040, 16'h0);
    req(1'b0, 1'b0, 16'h0040, 16'h0);
    chk("rd_busy_t1", busy0, 1'b1);
    chk("rd_no_req_t1", mem_request, 1'b0);
    step();
    chk("rd_req_t2", mem_request, 1'b1);
    chk("rd_addr_t2", mem_addr, 16'h0040);
    step();
    step();
    req(1'b0, 1'b0, 16'h9999, 16'h0);
    chk("dup_addr_kept", mem_addr, 16'h0040);
    chk("dup_busy", busy0, 1'b1);
    step();
    step();
    push_resp(1'b0, K_RDY, 16'hBEEF);
    do_resp(1'b0, 16'hBEEF);
    chk("rd_rdy0", rdy0, 1'b1);
    chk("rd_rdata", rdata, 16'hBEEF);
    chk("rd_busy_clear", busy0, 1'b0);
    req(1'b0, 1'b0, 16'h7777, 16'h0);
    chk("drop_on_pulse_busy", busy0, 1'b0);
    repeat (3) step();

    // Write on port 1: a stray mem_ready must not complete it.
    push_grant(1'b1, 1'b1, 16'h1234, 16'hA5A5);
    req(1'b1, 1'b1, 16'h1234, 16'hA5A5);
    step();
    chk("wr_req", mem_request, 1'b1);
    step();
    step();
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    chk("wr_ignore_ready", {rdy1, wdone1}, 2'b00);
    chk("wr_still_busy", busy1, 1'b1);
    chk("wr_hold", {mem_type, mem_addr, mem_wdata}, {1'b1, 16'h1234, 16'hA5A5});
    push_resp(1'b1, K_WDONE, 16'h0);
    do_resp(1'b1, 16'h0);
    chk("wr_wdone1", {wdone1, rdy1, busy1}, 3'b100);
    step();
    mem_ready = 1'b1;
    mem_write_complete = 1'b1;
    step();
    mem_ready = 1'b0;
    mem_write_complete = 1'b0;
    chk("idle_resp_ignored", {rdy0, rdy1, wdone0, wdone1, busy0, busy1}, 6'd0);
    step();

    // Response in the last counted WAIT cycle beats the abort.
    push_grant(1'b0, 1'b0, 16'h0066, 16'h0);
    req(1'b0, 1'b0, 16'h0066, 16'h0);
    step();
    repeat (TIMEOUT - 1) step();
    push_resp(1'b0, K_RDY, 16'hCAFE);
    do_resp(1'b0, 16'hCAFE);
    chk("edge_rdy_not_err", {rdy0, err0, timeout_flag}, 3'b100);
    step();

    // Timeout abort, then clear_err.
    push_grant(1'b0, 1'b0, 16'h0055, 16'h0);
    req(1'b0, 1'b0, 16'h0055, 16'h0);
    step();
    repeat (TIMEOUT - 1) step();
    chk("to_no_err_early", {err0, busy0}, 2'b01);
    push_resp(1'b0, K_ERR, 16'h0);
    step();
    chk("to_err0", {err0, timeout_flag, busy0}, 3'b110);
    step();
    chk("to_flag_sticky", {err0, timeout_flag}, 2'b01);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    chk("to_flag_cleared", timeout_flag, 1'b0);

    // clear_err coinciding with an abort leaves the flag set.
    push_grant(1'b0, 1'b0, 16'h0056, 16'h0);
    req(1'b0, 1'b0, 16'h0056, 16'h0);
    step();
    repeat (TIMEOUT - 1) step();
    push_resp(1'b0, K_ERR, 16'h0);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    chk("clr_vs_abort_flag", timeout_flag, 1'b1);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    chk("clr_after_abort", timeout_flag, 1'b0);

    // Reset in the middle of WAIT abandons the transfer silently.
    push_grant(1'b1, 1'b0, 16'h0ABC, 16'h0);
    req(1'b1, 1'b0, 16'h0ABC, 16'h0);
    step();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_reset("mid_wait_reset");
    repeat (TIMEOUT + 2) step();
    chk("post_reset_idle", {busy0, busy1, mem_request}, 3'b000);

    chk("grant_queue_empty", gq.size(), 0);
    chk("resp_queue_empty", rq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
